// File: rtl/uop_seq_pkg.sv
// Shared definitions for the microprogram sequencer and the program ROMs:
// opcode/exec codes, sequencer state encoding and uop field helpers.
package uop_seq_pkg;

    localparam int SEQ_UOP_W    = 20;
    localparam int SEQ_OPCODE_W = 4;
    localparam int SEQ_EXEC_W   = 2;

    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_NOP = 4'h0;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_MOV = 4'h1;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_ADD = 4'h2;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_SUB = 4'h3;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_MUL = 4'h4;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_SQR = 4'h5;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_INV = 4'h6;
    localparam logic [SEQ_OPCODE_W-1:0] OPCODE_RDY = 4'hF;

    // Code 2'b11 is reserved and executes unconditionally.
    localparam logic [SEQ_EXEC_W-1:0] EXEC_ALWAYS = 2'b00;
    localparam logic [SEQ_EXEC_W-1:0] EXEC_IF_SET = 2'b01;
    localparam logic [SEQ_EXEC_W-1:0] EXEC_IF_CLR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic [SEQ_OPCODE_W-1:0] uop_opcode(input logic [SEQ_UOP_W-1:0] w);
        return w[SEQ_UOP_W-1 -: SEQ_OPCODE_W];
    endfunction

    function automatic logic [SEQ_EXEC_W-1:0] uop_exec(input logic [SEQ_UOP_W-1:0] w);
        return w[SEQ_EXEC_W-1:0];
    endfunction

endpackage

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: fetches uops from a registered multi-program ROM,
// applies conditional skip and issues executed uops over valid/ready.
module uop_sequencer
    import uop_seq_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int PROG_W   = 2,
    parameter int UOP_W    = 20,
    parameter int OPCODE_W = 4,
    parameter int EXEC_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PROG_W-1:0]        prog_sel,
    input  logic                     cond_flag,
    output logic [PROG_W+ADDR_W-1:0] rom_addr,
    input  logic [UOP_W-1:0]         rom_data,
    output logic [UOP_W-1:0]         uop,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    seq_state_e                state, state_nxt;
    logic [ADDR_W-1:0]         pc, pc_nxt;
    logic                      fetched, fetched_nxt;
    logic [PROG_W+ADDR_W-1:0]  addr_nxt;
    logic [UOP_W-1:0]          uop_nxt;
    logic                      vld_nxt, busy_nxt, done_nxt, err_nxt;

    logic [PROG_W-1:0]   prog;
    logic [ADDR_W-1:0]   pc_inc, pc_inc2;
    logic [OPCODE_W-1:0] opcode;
    logic [EXEC_W-1:0]   exec;
    logic                last_pc, skip;

    assign prog    = rom_addr[PROG_W+ADDR_W-1 -: PROG_W];
    assign pc_inc  = pc + ADDR_W'(1);
    assign pc_inc2 = pc + ADDR_W'(2);
    assign last_pc = (pc == {ADDR_W{1'b1}});
    assign opcode  = rom_data[UOP_W-1 -: OPCODE_W];
    assign exec    = rom_data[EXEC_W-1:0];
    assign skip    = ((exec == EXEC_W'(EXEC_IF_SET)) && !cond_flag) ||
                     ((exec == EXEC_W'(EXEC_IF_CLR)) &&  cond_flag);

    // rom_addr runs one word ahead of pc once the first word is fetched, so
    // rom_data always holds word[pc] when WAIT decodes it.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        fetched_nxt = fetched;
        addr_nxt    = rom_addr;
        uop_nxt     = uop;
        vld_nxt     = uop_valid;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt    = {prog_sel, {ADDR_W{1'b0}}};
                    pc_nxt      = '0;
                    fetched_nxt = 1'b0;
                    err_nxt     = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!fetched) begin
                    fetched_nxt = 1'b1;
                    addr_nxt    = {prog, pc_inc};
                end else if (opcode == OPCODE_W'(OPCODE_RDY)) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_DONE;
                end else if (skip) begin
                    if (last_pc) begin
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt   = pc_inc;
                        addr_nxt = {prog, pc_inc2};
                    end
                end else begin
                    uop_nxt   = rom_data;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (uop_ready) begin
                    vld_nxt = 1'b0;
                    if (last_pc) begin
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt    = pc_inc;
                        addr_nxt  = {prog, pc_inc2};
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            fetched   <= 1'b0;
            rom_addr  <= '0;
            uop       <= '0;
            uop_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            fetched   <= fetched_nxt;
            rom_addr  <= addr_nxt;
            uop       <= uop_nxt;
            uop_valid <= vld_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: behavioural registered program ROM, timing model
// and a uop scoreboard queue.
module tb_uop_sequencer;
    import uop_seq_pkg::*;

    localparam logic [3:0] R_ZERO = 4'd0, R_ONE = 4'd1, R_X = 4'd2, R_Y = 4'd3, R_Z = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic        cond_flag = 1'b0;
    logic [7:0]  rom_addr;
    logic [19:0] rom_data = '0;
    logic [19:0] uop;
    logic        uop_valid;
    logic        uop_ready = 1'b1;
    logic        busy, done, err;

    logic [19:0] mem [256];
    logic [19:0] q [$];
    int n_chk = 0, n_err = 0;
    int done_cnt = 0, acc_cnt = 0;
    int stall_idx = -1, stall_left = 0;

    uop_sequencer #(.ADDR_W(6), .PROG_W(2), .UOP_W(20), .OPCODE_W(4), .EXEC_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .cond_flag(cond_flag),
        .rom_addr(rom_addr), .rom_data(rom_data), .uop(uop), .uop_valid(uop_valid),
        .uop_ready(uop_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] dst,
                                       input logic [3:0] src, input logic [5:0] pad,
                                       input logic [1:0] ex);
        return {op, dst, src, pad, ex};
    endfunction

    always @(posedge clk) begin
        #1;
        if (uop_valid && acc_cnt == stall_idx && stall_left > 0) begin
            uop_ready = 1'b0;
            stall_left--;
        end else begin
            uop_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (uop_valid) begin
            chk("uop_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                if (uop_ready) begin
                    chk("uop", 32'(uop), 32'(q.pop_front()));
                    acc_cnt++;
                end else begin
                    chk("uop_hold", 32'(uop), 32'(q[0]));
                end
            end
        end
    end

    // Expected uops go to the queue; returns done edge, err and first-valid edge.
    task automatic model(input int p, input logic c, output int dk, output logic de, output int df);
        int k;
        logic [19:0] w;
        logic sk;
        k = 2; de = 1'b0; dk = -1; df = -1;
        for (int pc = 0; pc < 64; pc++) begin
            w = mem[p*64 + pc];
            if (uop_opcode(w) == OPCODE_RDY) begin
                dk = k;
                break;
            end
            sk = (uop_exec(w) == EXEC_IF_SET && !c) || (uop_exec(w) == EXEC_IF_CLR && c);
            if (sk) begin
                if (pc == 63) begin dk = k; de = 1'b1; end
                else k += 1;
            end else begin
                q.push_back(w);
                if (df < 0) df = k;
                if (pc == 63) begin dk = k + 1; de = 1'b1; end
                else k += 2;
            end
        end
    endtask

    task automatic run_prog(input int p, input logic c, input bit spam, input int s_idx, input int s_len);
        int exp_k, exp_first, k, first, d0;
        logic exp_err;
        model(p, c, exp_k, exp_err, exp_first);
        exp_k += s_len;
        acc_cnt = 0; stall_idx = s_idx; stall_left = s_len; cond_flag = c;
        d0 = done_cnt;
        start = 1'b1; prog_sel = 2'(p);
        @(posedge clk); #1;
        start = spam;
        chk("busy_start", 32'(busy), 1);
        chk("rom_addr_start", 32'(rom_addr), 32'(p * 64));
        chk("err_clear_on_start", 32'(err), 0);
        k = -1; first = -1;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk); #1;
            if (uop_valid && first < 0) first = e;
            if (done) begin k = e; break; end
            if (spam) prog_sel = 2'($urandom);
        end
        chk("done_cycle", 32'(k), 32'(exp_k));
        chk("err_end", 32'(err), 32'(exp_err));
        chk("busy_end", 32'(busy), 0);
        chk("first_valid", 32'(first), 32'(exp_first));
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        @(posedge clk); #1;
        chk("idle_after_done", 32'(busy), 0);
        chk("uops_left", 32'(q.size()), 0);
        chk("done_count", 32'(done_cnt - d0), 1);
    endtask

    initial begin
        int exp_k, exp_first, d0;
        logic exp_err;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = mk(OPCODE_MOV, R_X, R_ONE, 6'd0, EXEC_ALWAYS);
        mem[1] = mk(OPCODE_MOV, R_Y, R_ONE, 6'd0, EXEC_ALWAYS);
        mem[2] = mk(OPCODE_MOV, R_Z, R_ZERO, 6'd0, EXEC_ALWAYS);
        mem[3] = mk(OPCODE_RDY, 4'd0, 4'd0, 6'd0, EXEC_ALWAYS);
        mem[64] = mem[0];
        mem[65] = mk(OPCODE_MOV, R_Y, R_ONE, 6'd0, EXEC_IF_SET);
        mem[66] = mem[2];
        mem[67] = mem[3];
        for (int i = 0; i < 64; i++) mem[128 + i] = mk(OPCODE_MOV, 4'(i), 4'(i >> 2), 6'(i), EXEC_IF_SET);
        mem[192] = mk(OPCODE_ADD, R_X, R_Y, 6'd1, EXEC_IF_CLR);
        mem[193] = mk(OPCODE_MUL, R_Y, R_Z, 6'd2, 2'b11);
        mem[194] = mk(OPCODE_SUB, R_Z, R_X, 6'd3, EXEC_IF_SET);
        mem[195] = mk(OPCODE_RDY, 4'd0, 4'd0, 6'd0, EXEC_ALWAYS);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_uop", 32'(uop), 0);
        chk("rst_uop_valid", 32'(uop_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_prog(0, 1'b0, 1'b0, -1, 0);
        run_prog(0, 1'b0, 1'b0, 1, 5);
        run_prog(1, 1'b0, 1'b0, -1, 0);
        run_prog(1, 1'b1, 1'b0, -1, 0);
        run_prog(3, 1'b1, 1'b0, -1, 0);
        run_prog(3, 1'b0, 1'b0, -1, 0);
        run_prog(2, 1'b1, 1'b0, -1, 0);
        run_prog(0, 1'b0, 1'b0, -1, 0);
        run_prog(2, 1'b0, 1'b0, -1, 0);
        run_prog(0, 1'b0, 1'b1, -1, 0);

        // Reset while a uop is held valid by back-pressure.
        model(0, 1'b0, exp_k, exp_err, exp_first);
        acc_cnt = 0; stall_idx = 0; stall_left = 1000; cond_flag = 1'b0;
        d0 = done_cnt;
        start = 1'b1; prog_sel = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (uop_valid) break;
        end
        chk("valid_before_rst", 32'(uop_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_rom_addr", 32'(rom_addr), 0);
        chk("midrst_uop", 32'(uop), 0);
        chk("midrst_uop_valid", 32'(uop_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        stall_left = 0; stall_idx = -1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_cnt - d0), 0);
        chk("idle_after_rst", 32'(busy), 0);
        run_prog(0, 1'b0, 1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uop_sequencer.md
# uop_sequencer

Parametrised microprogram sequencer for the curve point engine. It selects one of several microprograms (init, double, add, ...) stored in an external registered ROM and fetches micro-operations one at a time. It applies per-uop conditional execution, hands each executed uop to the datapath over a valid/ready handshake, and stops at the RDY opcode. It generalises the fixed single-program init ROM: programs are selectable, depth is parametrised, and it adds back-pressure, conditional skip and overflow detection.

## Interface
- ADDR_W, 6: uop address width within one program (depth 2^ADDR_W).
- PROG_W, 2: program-select width (2^PROG_W programs).
- UOP_W, 20: uop word width.
- OPCODE_W, 4: opcode field, bits [UOP_W-1 -: OPCODE_W].
- EXEC_W, 2: exec-condition field, bits [EXEC_W-1:0].
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset asynchronous and active-high.
- start  in  1  single-cycle start request.
- prog_sel  in  PROG_W  program to run; sampled with start.
- cond_flag  in  1  condition flag from the datapath, sampled when a uop is decoded.
- rom_addr  out  PROG_W+ADDR_W  {program, pc} to the ROM; registered.
- rom_data  in  UOP_W  ROM word; valid one cycle after rom_addr changes.
- uop  out  UOP_W  current uop; registered.
- uop_valid  out  1  uop is presented.
- uop_ready  in  1  datapath accepts uop.
- busy  out  1  program in progress.
- done  out  1  one-cycle pulse at program end.
- err  out  1  sticky: pc overflowed without RDY; cleared by the next accepted start.

## Operation
- States: IDLE, WAIT, ISSUE, DONE.
- IDLE: on start, rom_addr <= {prog_sel, 0}, pc <= 0, err <= 0, busy <= 1, go to WAIT. Without start, stay in IDLE.
- WAIT: the ROM word for pc is on rom_data. Decode it:
  - opcode == OPCODE_RDY: go to DONE. No uop is issued.
  - exec == EXEC_IF_SET with cond_flag=0, or exec == EXEC_IF_CLR with cond_flag=1: skip. pc increments, rom_addr updates, stay in WAIT.
  - otherwise: uop <= rom_data, uop_valid <= 1, go to ISSUE.
  - A skip at pc = 2^ADDR_W-1 sets err and goes to DONE.
- ISSUE: hold uop and uop_valid stable until uop_ready. On the handshake edge:
  - uop_valid <= 0;
  - if pc = 2^ADDR_W-1: err <= 1, go to DONE;
  - else: pc increments, rom_addr updates, go to WAIT.
- DONE: done = 1 for exactly one cycle, busy <= 0, go to IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- prog_sel is only sampled with an accepted start.
- EXEC_ALWAYS and the reserved exec code both execute unconditionally.
- pc is ADDR_W bits wide and never wraps silently; overflow always ends the program with err.
- rst asserted mid-program: immediate return to IDLE. The in-flight uop is dropped and no done pulse is generated.

## Timing
- Reset values: rom_addr=0, uop=0, uop_valid=0, busy=0, done=0, err=0, state=IDLE.
- All outputs are registered; there is no combinational path from uop_ready or cond_flag to any output.
- Start latency: start sampled at edge E0 gives rom_addr valid after E0, rom_data valid after E1, and the first uop_valid after E2.
- Throughput: 2 cycles per executed uop with uop_ready held high. Each skipped uop costs 1 cycle.
- End of program: RDY decoded at edge Ek asserts done for the cycle after Ek, with busy low from that edge. IDLE accepts a new start in the cycle after done.
- A program of N executed uops, no skips and ready always high: done is high 2N+2 cycles after the start edge.

## Structure
- Shared package uop_seq_pkg holds:
  - the OPCODE_* constants, including OPCODE_RDY, shared with the ROMs;
  - the EXEC_ALWAYS, EXEC_IF_SET and EXEC_IF_CLR codes;
  - the state encoding;
  - field-slice helpers for opcode and exec.
- No sub-module inside the sequencer. The program store is a separate multi-program ROM, uop_prog_rom, indexed by {program, pc}, with one-cycle registered read.

## Test plan
- Init program (MOV ONE->RX, MOV ONE->RY, MOV ZERO->RZ, RDY) with uop_ready=1 and start at edge 0 -> three uops issued, first valid after edge 2, done after edge 8, err=0.
- Same program with uop_ready low for 5 cycles on the second uop -> uop stays stable and valid throughout, no uop lost or duplicated, done delayed by exactly 5 cycles.
- uop 1 tagged EXEC_IF_SET: cond_flag=0 -> only 2 uops issued and done 1 cycle earlier; cond_flag=1 -> all 3 issued.
- Program of 64 MOVs with no RDY -> 64 uops issued, then err=1 with a done pulse. A following start clears err.
- start pulsed in every cycle while busy -> only the first start is accepted, and prog_sel changes during the run have no effect.
- rst asserted while uop_valid=1 -> all outputs return to their reset values at once, no done pulse, and the next start runs normally.
